// File: rtl/hazard_fwd_unit.sv
// Operand forwarding selects and load-use stall/bubble generation for a 5-stage pipeline.
// Outputs are combinational from this cycle's inputs; a load-use hazard holds PC/IF-ID for MEM_LAT cycles.
module hazard_fwd_unit #(
  parameter int ADDRESS_W = 5,
  parameter int NUM_RS    = 2,
  parameter int MEM_LAT   = 1,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [NUM_RS*ADDRESS_W-1:0] ifid_rs,
  input  logic [NUM_RS-1:0]           ifid_rs_used,
  input  logic [NUM_RS*ADDRESS_W-1:0] idex_rs,
  input  logic [ADDRESS_W-1:0]        idex_rd,
  input  logic                        idex_memread,
  input  logic [ADDRESS_W-1:0]        exmem_wa,
  input  logic                        exmem_regwrt,
  input  logic [ADDRESS_W-1:0]        memwb_wa,
  input  logic                        memwb_regwrt,
  output logic [NUM_RS*2-1:0]         fwdsrc,
  output logic                        stall,
  output logic                        idex_bubble,
  output logic [CNT_W-1:0]            stall_count
);

  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic {IDLE, STALL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic            haz_hit;
  logic            haz;
  logic            stall_c;

  always_comb begin
    fwdsrc  = '0;
    haz_hit = 1'b0;
    for (int k = 0; k < NUM_RS; k++) begin
      // EX/MEM holds the youngest result, so it is tested first.
      if (exmem_regwrt && (exmem_wa != '0) &&
          (exmem_wa == idex_rs[k*ADDRESS_W +: ADDRESS_W])) begin
        fwdsrc[k*2 +: 2] = 2'b10;
      end else if (memwb_regwrt && (memwb_wa != '0) &&
                   (memwb_wa == idex_rs[k*ADDRESS_W +: ADDRESS_W])) begin
        fwdsrc[k*2 +: 2] = 2'b01;
      end
      if (ifid_rs_used[k] && (ifid_rs[k*ADDRESS_W +: ADDRESS_W] == idex_rd)) begin
        haz_hit = 1'b1;
      end
    end
    if (!rst_n) begin
      fwdsrc = '0;
    end
  end

  assign haz = idex_memread && (idex_rd != '0) && haz_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (haz && !flush) begin
          stall_c = 1'b1;
          if (MEM_LAT > 1) begin
            state_d = STALL;
            cnt_d   = CW'(MEM_LAT - 1);
          end
        end
      end
      STALL: begin
        // ID/EX already holds a bubble here, so haz is not consulted.
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (!rst_n) begin
      stall_c = 1'b0;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_c && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall       = stall_c;
  assign idex_bubble = stall_c;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit across MEM_LAT=1/3/4 and a 2-bit stall counter instance.
module tb_hazard_fwd_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, rst3, rst4, rsts;
  logic       flush;
  logic [9:0] ifid_rs;
  logic [1:0] ifid_rs_used;
  logic [9:0] idex_rs;
  logic [4:0] idex_rd;
  logic       idex_memread;
  logic [4:0] exmem_wa;
  logic       exmem_regwrt;
  logic [4:0] memwb_wa;
  logic       memwb_regwrt;

  logic [3:0]  fw1, fw3, fw4, fws;
  logic        st1, st3, st4, sts;
  logic        bb1, bb3, bb4, bbs;
  logic [15:0] sc1, sc3, sc4;
  logic [1:0]  scs;

  hazard_fwd_unit #(.ADDRESS_W(5), .NUM_RS(2), .MEM_LAT(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst1), .flush(flush), .ifid_rs(ifid_rs), .ifid_rs_used(ifid_rs_used),
    .idex_rs(idex_rs), .idex_rd(idex_rd), .idex_memread(idex_memread), .exmem_wa(exmem_wa),
    .exmem_regwrt(exmem_regwrt), .memwb_wa(memwb_wa), .memwb_regwrt(memwb_regwrt),
    .fwdsrc(fw1), .stall(st1), .idex_bubble(bb1), .stall_count(sc1));

  hazard_fwd_unit #(.ADDRESS_W(5), .NUM_RS(2), .MEM_LAT(3), .CNT_W(16)) u3 (
    .clk(clk), .rst_n(rst3), .flush(flush), .ifid_rs(ifid_rs), .ifid_rs_used(ifid_rs_used),
    .idex_rs(idex_rs), .idex_rd(idex_rd), .idex_memread(idex_memread), .exmem_wa(exmem_wa),
    .exmem_regwrt(exmem_regwrt), .memwb_wa(memwb_wa), .memwb_regwrt(memwb_regwrt),
    .fwdsrc(fw3), .stall(st3), .idex_bubble(bb3), .stall_count(sc3));

  hazard_fwd_unit #(.ADDRESS_W(5), .NUM_RS(2), .MEM_LAT(4), .CNT_W(16)) u4 (
    .clk(clk), .rst_n(rst4), .flush(flush), .ifid_rs(ifid_rs), .ifid_rs_used(ifid_rs_used),
    .idex_rs(idex_rs), .idex_rd(idex_rd), .idex_memread(idex_memread), .exmem_wa(exmem_wa),
    .exmem_regwrt(exmem_regwrt), .memwb_wa(memwb_wa), .memwb_regwrt(memwb_regwrt),
    .fwdsrc(fw4), .stall(st4), .idex_bubble(bb4), .stall_count(sc4));

  hazard_fwd_unit #(.ADDRESS_W(5), .NUM_RS(2), .MEM_LAT(1), .CNT_W(2)) us (
    .clk(clk), .rst_n(rsts), .flush(flush), .ifid_rs(ifid_rs), .ifid_rs_used(ifid_rs_used),
    .idex_rs(idex_rs), .idex_rd(idex_rd), .idex_memread(idex_memread), .exmem_wa(exmem_wa),
    .exmem_regwrt(exmem_regwrt), .memwb_wa(memwb_wa), .memwb_regwrt(memwb_regwrt),
    .fwdsrc(fws), .stall(sts), .idex_bubble(bbs), .stall_count(scs));

  typedef struct {
    string      name;
    int         inst;
    logic [3:0] fwd;
    logic       stl;
    logic       bub;
    int         cnt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int inst, input logic [3:0] f,
                     input logic s, input logic b, input int c);
    exp_t e;
    e.name = nm; e.inst = inst; e.fwd = f; e.stl = s; e.bub = b; e.cnt = c;
    sbq.push_back(e);
  endtask

  // Monitor: every falling edge, score all expectations queued for the current cycle.
  exp_t       me;
  logic [3:0] af;
  logic       as_, ab;
  int         ac;
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      me = sbq.pop_front();
      case (me.inst)
        1:       begin af = fw1; as_ = st1; ab = bb1; ac = int'(sc1); end
        3:       begin af = fw3; as_ = st3; ab = bb3; ac = int'(sc3); end
        4:       begin af = fw4; as_ = st4; ab = bb4; ac = int'(sc4); end
        default: begin af = fws; as_ = sts; ab = bbs; ac = int'(scs); end
      endcase
      checks++;
      if (af !== me.fwd) begin
        errors++;
        $display("FAIL %s[u%0d] fwdsrc got %b want %b", me.name, me.inst, af, me.fwd);
      end
      checks++;
      if (as_ !== me.stl) begin
        errors++;
        $display("FAIL %s[u%0d] stall got %b want %b", me.name, me.inst, as_, me.stl);
      end
      checks++;
      if (ab !== me.bub) begin
        errors++;
        $display("FAIL %s[u%0d] idex_bubble got %b want %b", me.name, me.inst, ab, me.bub);
      end
      checks++;
      if (ac !== me.cnt) begin
        errors++;
        $display("FAIL %s[u%0d] stall_count got %0d want %0d", me.name, me.inst, ac, me.cnt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    flush = 1'b0; ifid_rs = '0; ifid_rs_used = '0; idex_rs = '0; idex_rd = '0;
    idex_memread = 1'b0; exmem_wa = '0; exmem_regwrt = 1'b0; memwb_wa = '0; memwb_regwrt = 1'b0;
  endtask

  task automatic haz_in();
    idle_in();
    idex_memread = 1'b1; idex_rd = 5'd7; ifid_rs = {5'd0, 5'd7}; ifid_rs_used = 2'b01;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0; rsts = 1'b0;
    idle_in();
    step();

    // Reset holds every output low even with a forwarding/hazard match on the inputs.
    haz_in(); idex_rs = {5'd5, 5'd5}; exmem_wa = 5'd5; exmem_regwrt = 1'b1;
    chk("reset", 1, 4'b0000, 0, 0, 0);
    chk("reset", 3, 4'b0000, 0, 0, 0);
    chk("reset", 4, 4'b0000, 0, 0, 0);
    chk("reset", 5, 4'b0000, 0, 0, 0);
    step();

    rst1 = 1'b1;
    idle_in(); idex_rs = {5'd5, 5'd5}; exmem_wa = 5'd5; exmem_regwrt = 1'b1;
    memwb_wa = 5'd5; memwb_regwrt = 1'b1;
    chk("fwd_both", 1, 4'b1010, 0, 0, 0);
    step();
    exmem_regwrt = 1'b0;
    chk("fwd_memwb", 1, 4'b0101, 0, 0, 0);
    step();
    exmem_regwrt = 1'b1; exmem_wa = 5'd0; memwb_wa = 5'd0;
    chk("fwd_zero_addr", 1, 4'b0000, 0, 0, 0);
    step();
    idex_rs = {5'd3, 5'd9}; exmem_wa = 5'd9; memwb_wa = 5'd3;
    chk("fwd_mixed", 1, 4'b0110, 0, 0, 0);
    step();

    haz_in();
    chk("lu1_stall", 1, 4'b0000, 1, 1, 0);
    step();
    idle_in(); idex_rs = {5'd0, 5'd7}; memwb_wa = 5'd7; memwb_regwrt = 1'b1;
    chk("lu1_after", 1, 4'b0001, 0, 0, 1);
    step();
    haz_in(); ifid_rs_used = 2'b00;
    chk("lu1_unused", 1, 4'b0000, 0, 0, 1);
    step();
    haz_in(); ifid_rs = {5'd7, 5'd0}; ifid_rs_used = 2'b10;
    chk("lu1_op1", 1, 4'b0000, 1, 1, 1);
    step();
    idle_in();
    chk("lu1_op1_after", 1, 4'b0000, 0, 0, 2);
    step();
    idle_in(); idex_memread = 1'b1; ifid_rs_used = 2'b11;
    chk("lu1_rd_zero", 1, 4'b0000, 0, 0, 2);
    step();

    rst3 = 1'b1;
    haz_in();
    chk("lu3_c0", 3, 4'b0000, 1, 1, 0);
    step();
    idle_in();
    chk("lu3_c1", 3, 4'b0000, 1, 1, 1);
    step();
    chk("lu3_c2", 3, 4'b0000, 1, 1, 2);
    step();
    chk("lu3_done", 3, 4'b0000, 0, 0, 3);
    step();
    chk("lu3_idle", 3, 4'b0000, 0, 0, 3);
    step();

    haz_in();
    chk("fl_c0", 3, 4'b0000, 1, 1, 3);
    step();
    idle_in(); flush = 1'b1;
    chk("fl_flush", 3, 4'b0000, 0, 0, 4);
    step();
    idle_in();
    chk("fl_idle", 3, 4'b0000, 0, 0, 4);
    step();
    haz_in(); flush = 1'b1;
    chk("fl_haz_idle", 3, 4'b0000, 0, 0, 4);
    step();
    idle_in();
    chk("fl_haz_after", 3, 4'b0000, 0, 0, 4);
    step();

    rst4 = 1'b1;
    haz_in();
    chk("rs_c0", 4, 4'b0000, 1, 1, 0);
    step();
    idle_in(); rst4 = 1'b0; idex_rs = {5'd5, 5'd5}; exmem_wa = 5'd5; exmem_regwrt = 1'b1;
    chk("rs_in_reset", 4, 4'b0000, 0, 0, 1);
    step();
    idle_in(); rst4 = 1'b1;
    chk("rs_released", 4, 4'b0000, 0, 0, 0);
    step();
    chk("rs_no_residual", 4, 4'b0000, 0, 0, 0);
    step();

    rsts = 1'b1;
    haz_in();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("sat_%0d", i), 5, 4'b0000, 1, 1, (i > 3) ? 3 : i);
      step();
    end
    idle_in();
    chk("sat_hold", 5, 4'b0000, 0, 0, 3);
    step();

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
